// File: rtl/dram_ctrl_if.sv
// dram_ctrl_if: Avalon-style host bus used by the CPU and debug ports of dram_ctrl.
// Signals:
//   address     32  byte address
//   read/write   1  request strobes (held stable while waitrequest=1)
//   writedata   32  write data
//   readdata    32  read data, valid when read && !waitrequest
//   waitrequest  1  stall from the controller
// Modports: master (host side), slave (controller side).
interface dram_ctrl_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/dram_ctrl.sv
// dram_ctrl: sequencer and arbiter in front of a single-port RAM
// (combinational read, single-cycle write). Two hosts (CPU, debug) share the
// RAM with round-robin arbitration; a fill engine writes an arithmetic series
// into a RAM region on command and owns the RAM while busy.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu, dbg              host buses (dram_ctrl_if.slave)
//   i_fill_start          one-cycle fill command
//   i_fill_base/count     first byte address / number of words
//   i_fill_init/step      first value / increment
//   o_fill_busy           fill engine owns the RAM
//   o_fill_done           one-cycle completion pulse
//   o_ram_*/i_ram_readdata RAM side
module dram_ctrl #(
  parameter int CNT_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  dram_ctrl_if.slave        cpu,
  dram_ctrl_if.slave        dbg,
  input  logic              i_fill_start,
  input  logic [31:0]       i_fill_base,
  input  logic [CNT_W-1:0]  i_fill_count,
  input  logic [31:0]       i_fill_init,
  input  logic [31:0]       i_fill_step,
  output logic              o_fill_busy,
  output logic              o_fill_done,
  output logic [31:0]       o_ram_address,
  output logic              o_ram_read,
  output logic              o_ram_write,
  output logic [31:0]       o_ram_writedata,
  input  logic [31:0]       i_ram_readdata
);

  // state  | meaning
  // S_IDLE | hosts arbitrated, waiting for i_fill_start
  // S_FILL | one RAM write per cycle from the fill engine
  // S_DONE | o_fill_done pulse, RAM still withheld from hosts
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } fill_state_t;

  fill_state_t        r_state;
  fill_state_t        w_state_nxt;
  logic [31:0]        r_addr;
  logic [31:0]        r_val;
  logic [31:0]        r_step;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_last_dbg;   // 1: debug port was granted most recently

  logic w_busy;
  logic w_cpu_req;
  logic w_dbg_req;
  logic w_grant_cpu;
  logic w_grant_dbg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_fill_start)
          w_state_nxt = (i_fill_count == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        if (r_remaining == CNT_W'(1)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fill datapath; address and value wrap modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_val       <= '0;
      r_step      <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_fill_start) begin
            r_addr      <= i_fill_base;
            r_val       <= i_fill_init;
            r_step      <= i_fill_step;
            r_remaining <= i_fill_count;
          end
        end
        S_FILL: begin
          r_addr      <= r_addr + 32'd4;
          r_val       <= r_val + r_step;
          r_remaining <= r_remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign w_busy      = (r_state != S_IDLE);
  assign o_fill_busy = w_busy;
  assign o_fill_done = (r_state == S_DONE);

  assign w_cpu_req = cpu.read | cpu.write;
  assign w_dbg_req = dbg.read | dbg.write;

  // On a tie the host that did not win last time is granted.
  always_comb begin
    w_grant_cpu = 1'b0;
    w_grant_dbg = 1'b0;
    if (!w_busy) begin
      if (w_cpu_req && w_dbg_req) begin
        w_grant_cpu = r_last_dbg;
        w_grant_dbg = !r_last_dbg;
      end else begin
        w_grant_cpu = w_cpu_req;
        w_grant_dbg = w_dbg_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_last_dbg <= 1'b1;
    else if (w_grant_cpu) r_last_dbg <= 1'b0;
    else if (w_grant_dbg) r_last_dbg <= 1'b1;
  end

  always_comb begin
    o_ram_address   = '0;
    o_ram_read      = 1'b0;
    o_ram_write     = 1'b0;
    o_ram_writedata = '0;
    if (r_state == S_FILL) begin
      o_ram_address   = r_addr;
      o_ram_write     = 1'b1;
      o_ram_writedata = r_val;
    end else if (w_grant_cpu) begin
      o_ram_address   = cpu.address;
      o_ram_read      = cpu.read;
      o_ram_write     = cpu.write;
      o_ram_writedata = cpu.writedata;
    end else if (w_grant_dbg) begin
      o_ram_address   = dbg.address;
      o_ram_read      = dbg.read;
      o_ram_write     = dbg.write;
      o_ram_writedata = dbg.writedata;
    end
  end

  assign cpu.waitrequest = w_cpu_req & ~w_grant_cpu;
  assign dbg.waitrequest = w_dbg_req & ~w_grant_dbg;
  assign cpu.readdata    = w_grant_cpu ? i_ram_readdata : 32'd0;
  assign dbg.readdata    = w_grant_dbg ? i_ram_readdata : 32'd0;

endmodule

// File: doc/dram_ctrl.md
# dram_ctrl

Sequencer and arbiter in front of the single-port test data RAM (combinational read, single-cycle write). Shares the RAM between the CPU data port and a debug/loader port with round-robin arbitration and Avalon-style waitrequest. Contains a fill engine that writes an arithmetic series into a RAM region on command, so benches can initialise memory without poking arrays hierarchically.

## Interface
Parameters:
- CNT_W, 13, width of fill word count (max 4096 words)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_address  in  32  CPU byte address
- cpu_read / cpu_write  in  1 each  CPU request strobes
- cpu_writedata  in  32  CPU write data
- cpu_readdata  out  32  CPU read data, valid when cpu_read && !cpu_waitrequest
- cpu_waitrequest  out  1  CPU stall
- dbg_address, dbg_read, dbg_write, dbg_writedata, dbg_readdata, dbg_waitrequest: same as cpu_* for the debug port
- fill_start  in  1  one-cycle fill command
- fill_base  in  32  first fill address
- fill_count  in  CNT_W  number of words to write
- fill_init / fill_step  in  32 each  first value, increment
- fill_busy  out  1  fill engine owns RAM
- fill_done  out  1  one-cycle completion pulse
- ram_address  out  32, ram_read  out  1, ram_write  out  1, ram_writedata  out  32, ram_readdata  in  32: RAM side

## Operation
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE: fill_start=1 latches base, count, init, step; count==0 -> DONE, else -> FILL. fill_start ignored in FILL/DONE.
  - FILL: each cycle ram_write=1, ram_address=addr_q, ram_writedata=val_q; then addr_q+=4, val_q+=step (both mod 2^32, wrap silently), remaining-=1; remaining reaches 0 -> DONE.
  - DONE: fill_done=1 for exactly one cycle -> IDLE.
  - fill_busy=1 in FILL and DONE.
- Arbitration (combinational grant, at most one requester per cycle):
  - fill_busy=1: no host granted; both waitrequests follow their own read|write.
  - Else only one host requesting: that host granted.
  - Both requesting: grant host not granted most recently; last_grant register updates on every host grant; reset value = dbg (so CPU wins first tie).
  - waitrequest = (read|write) && !granted; 0 when idle.
- Granted host drives ram_address/writedata/read/write directly; its readdata = ram_readdata; non-granted readdata = 0.
- read and write both asserted: write performed; readdata shows pre-write contents.
- No host granted and not filling: ram_read=ram_write=0, ram_address=0, ram_writedata=0.

## Timing
- Reset values: fill_busy=0, fill_done=0, FSM=IDLE, last_grant=dbg, ram_read=ram_write=0; waitrequests/readdata follow combinational rules (0 with no requests).
- Granted access: zero added latency; read data valid in the same cycle; write committed at the rising edge ending the grant cycle.
- Host must hold address/data/strobes stable while waitrequest=1.
- Fill of N words: fill_start at edge 0 -> writes in cycles 1..N -> fill_done in cycle N+1 -> hosts arbitrated again from cycle N+2. count==0: fill_done in cycle 1, no writes.
- fill_start in same cycle as host requests: that cycle's host grant still proceeds; fill owns RAM from next cycle.
- rst_n low mid-fill: FSM to IDLE immediately, no fill_done, words already written remain.

## Test plan
- Reset then idle: all outputs 0, fill_busy=0; first CPU read of 0x0 granted same cycle, waitrequest=0.
- Fill base=0x0, count=30, init=0x12345678, step=0xdcba1234: 30 consecutive writes; word at 0x74 = 0x12345678+29*0xdcba1234 mod 2^32; fill_done one cycle at cycle 31.
- Contention: CPU and dbg hold reads for 4 cycles -> grants CPU,dbg,CPU,dbg; non-granted waitrequest=1 each cycle.
- CPU write 0xDEADBEEF to 0x10 during fill -> cpu_waitrequest=1 until fill_done+1, then written; readback 0xDEADBEEF.
- fill_count=0 -> fill_done in cycle 1, no ram_write; fill_start while busy ignored (count unchanged).
- Assert rst_n low after 5 fill writes -> fill_busy=0 asynchronously, no fill_done, words 0..4 written, word 5 unchanged.
